cpu_bus_sequencer: RTL

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

---
 rtl/cpu_bus_sequencer_pkg.sv | 37 +++
 rtl/bus_cmd_fifo.sv | 69 ++++++
 rtl/cpu_bus_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared definitions for the CPU bus sequencer: the 8088 S2..S0 status codes,
// the sequencer state encoding, and helpers that classify a status code.
// Latency: n/a (types and functions only). Backpressure: n/a.
package cpu_bus_sequencer_pkg;

    // 8088 bus cycle codes as they appear on S2..S0.
    typedef enum logic [2:0] {
        ST_INTA    = 3'b000,
        ST_IOR     = 3'b001,
        ST_IOW     = 3'b010,
        ST_HALT    = 3'b011,
        ST_CODE    = 3'b100,
        ST_MEMR    = 3'b101,
        ST_MEMW    = 3'b110,
        ST_PASSIVE = 3'b111
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STATUS,
        S_WAIT,
        S_RELEASE,
        S_GAP,
        S_DELAY
    } state_e;

    // Cycles that return data to the requester.
    function automatic logic is_read(input status_e s);
        return (s == ST_INTA) || (s == ST_IOR) || (s == ST_CODE) || (s == ST_MEMR);
    endfunction

    // Cycles that drive the data bus.
    function automatic logic is_write(input status_e s);
        return (s == ST_IOW) || (s == ST_MEMW);
    endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Command queue for the bus sequencer: flat-vector FIFO with first-word-fall-through head.
// Latency: a pushed entry is visible at the head one clock after the push.
// Backpressure: wr_rdy is low while full; a push offered while full is dropped even if a pop happens in the same clock.
//
// Ports: clock/reset (async, active-high); wr_vld/wr_rdy/wr_dat push side;
//        rd_en pops the head, rd_dat is the current head, empty flags no head.
module bus_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH (full) and 0 (empty) are distinct.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Ready comes straight from the registered count, so it never depends on
    // a pop happening in the same clock.
    assign wr_rdy  = (count != FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = wr_vld && wr_rdy;
    assign do_pop  = rd_en && !empty;
    assign rd_dat  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Replays queued commands as 8088-style bus cycles (status, wait states, release, gap) and returns read data.
// Latency: a queued command starts driving status one clock after the FSM pops it; read response one clock after completion.
// Backpressure: cmd_ready follows the queue's registered not-full flag; the bus throttles via processor_ready wait states.
//
// Ports: clock, reset (async, active-high)
//        cmd_valid/cmd_ready/cmd_type/cmd_address/cmd_data : command queue input
//        processor_ready, data_bus_in                      : bus handshake and read data
//        cpu_address, cpu_data_bus, processor_status       : driven bus cycle
//        rsp_valid, rsp_data, rsp_error                    : read completion / wait timeout pulses
//        busy                                              : FSM active or commands pending
module cpu_bus_sequencer
    import cpu_bus_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STATUS_CYCLES = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int WAIT_LIMIT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_type,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  processor_ready,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [ADDR_WIDTH-1:0] cpu_address,
    output logic [DATA_WIDTH-1:0] cpu_data_bus,
    output logic [2:0]            processor_status,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int CMD_W = 3 + ADDR_WIDTH + DATA_WIDTH;
    // One counter serves STATUS, GAP and DELAY; DELAY needs the full data range.
    localparam int CNT_W = DATA_WIDTH + $clog2(STATUS_CYCLES + GAP_CYCLES);
    localparam int WC_W  = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] STATUS_LAST = CNT_W'(STATUS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    localparam logic [WC_W-1:0]  WAIT_LAST   = WC_W'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);

    // Command queue
    logic [CMD_W-1:0]      head_dat;
    logic                  fifo_empty;
    logic                  pop;
    status_e               head_type;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Sequencer state
    state_e                state;
    status_e               cur_type;
    logic [CNT_W-1:0]      cnt;
    logic [WC_W-1:0]       wait_cnt;

    bus_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_vld (cmd_valid),
        .wr_rdy (cmd_ready),
        .wr_dat ({cmd_type, cmd_address, cmd_data}),
        .rd_en  (pop),
        .rd_dat (head_dat),
        .empty  (fifo_empty)
    );

    assign head_type = status_e'(head_dat[CMD_W-1 -: 3]);
    assign head_addr = head_dat[DATA_WIDTH +: ADDR_WIDTH];
    assign head_data = head_dat[DATA_WIDTH-1:0];

    // The head is consumed in the same clock the FSM leaves IDLE.
    assign pop  = (state == S_IDLE) && !fifo_empty;
    assign busy = (state != S_IDLE) || !fifo_empty;

    // Outputs are updated on the transition into each state, so what the bus
    // sees in a state is exactly what was loaded when that state was entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cur_type         <= ST_PASSIVE;
            cnt              <= '0;
            wait_cnt         <= '0;
            processor_status <= ST_PASSIVE;
            cpu_address      <= '0;
            cpu_data_bus     <= '0;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_data         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur_type <= head_type;
                        cnt      <= '0;
                        if (head_type == ST_PASSIVE) begin
                            // Passive code is a pure time delay of data+1 clocks.
                            state            <= S_DELAY;
                            cnt              <= CNT_W'(head_data);
                            processor_status <= ST_PASSIVE;
                            cpu_address      <= '0;
                            cpu_data_bus     <= '0;
                        end else begin
                            state            <= S_STATUS;
                            processor_status <= head_type;
                            cpu_address      <= head_addr;
                            cpu_data_bus     <= is_write(head_type) ? head_data : '0;
                        end
                    end
                end

                S_STATUS: begin
                    if (cnt == STATUS_LAST) begin
                        // Halt transfers nothing, so it never waits on ready.
                        if (cur_type == ST_HALT || processor_ready) begin
                            if (is_read(cur_type)) begin
                                rsp_data  <= data_bus_in;
                                rsp_valid <= 1'b1;
                            end
                            state            <= S_RELEASE;
                            processor_status <= ST_PASSIVE;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (processor_ready) begin
                        if (is_read(cur_type)) begin
                            rsp_data  <= data_bus_in;
                            rsp_valid <= 1'b1;
                        end
                        state            <= S_RELEASE;
                        processor_status <= ST_PASSIVE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Timed out: abandon the cycle without read data.
                        rsp_error        <= 1'b1;
                        state            <= S_RELEASE;
                        processor_status <= ST_PASSIVE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    cpu_address  <= '0;
                    cpu_data_bus <= '0;
                    cnt          <= '0;
                    state        <= (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DELAY: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
